conv_window_gen: RTL

- Producer side of the 3x3 convolution interface: turns a raster-order grayscale pixel stream (one pixel per cycle at most) into 3x3 pixel windows plus a one-cycle valid strobe.
- Feeds the conv engine's 3x3 pixel-grid input and data-valid input directly.
- Holds two full image rows in line buffers; emits only windows lying fully inside the image (no padding).
- Produces (IMG_WIDTH-2) x (IMG_HEIGHT-2) windows per frame.

---
 rtl/conv_window_gen_if.sv | 27 ++
 rtl/conv_window_gen.sv | 105 ++++++++++
 2 files changed

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen_if
// Brief    : Pixel-stream input and 3x3 window output bundle for conv_window_gen.
// Revision : 1.0  initial release
// ============================================================================
interface conv_window_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                                  start_i;
    logic [PIXEL_WIDTH-1:0]                pixel_i;
    logic                                  pixel_valid_i;
    logic [2:0][2:0][PIXEL_WIDTH-1:0]      window_o;
    logic                                  window_valid_o;
    logic                                  frame_done_o;

    modport master (
        output start_i, pixel_i, pixel_valid_i,
        input  window_o, window_valid_o, frame_done_o
    );

    modport slave (
        input  start_i, pixel_i, pixel_valid_i,
        output window_o, window_valid_o, frame_done_o
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Brief    : Raster pixel stream to in-image 3x3 windows using two line buffers.
// Revision : 1.0  initial release
// ============================================================================
module conv_window_gen #(
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int PIXEL_WIDTH = 8
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    conv_window_gen_if.slave    bus
);
    localparam int c_col_w = $clog2(IMG_WIDTH);
    localparam int c_row_w = $clog2(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);

    typedef logic [PIXEL_WIDTH-1:0] pix_t;
    typedef pix_t [2:0][2:0]        win_t;

    logic [c_col_w-1:0] col_q, col_d, w_col_rd;
    logic [c_row_w-1:0] row_q, row_d, w_row_rd;
    pix_t               lb0_q [IMG_WIDTH];
    pix_t               lb1_q [IMG_WIDTH];
    win_t               win_q, win_d;
    win_t               window_q, window_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               w_accept;
    logic               w_emit;
    pix_t [2:0]         w_new_col;

    always_comb begin
        // A start pulse relocates this cycle's pixel (if any) to (0,0).
        w_col_rd     = bus.start_i ? '0 : col_q;
        w_row_rd     = bus.start_i ? '0 : row_q;
        w_accept     = bus.pixel_valid_i;
        w_new_col[0] = lb0_q[w_col_rd];
        w_new_col[1] = lb1_q[w_col_rd];
        w_new_col[2] = bus.pixel_i;

        col_d    = w_col_rd;
        row_d    = w_row_rd;
        win_d    = win_q;
        window_d = window_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        w_emit   = w_accept && !bus.start_i
                   && (w_row_rd >= c_row_w'(2)) && (w_col_rd >= c_col_w'(2));

        if (w_accept) begin
            if (w_col_rd == c_col_last) begin
                col_d = '0;
                row_d = (w_row_rd == c_row_last) ? '0 : w_row_rd + c_row_w'(1);
            end else begin
                col_d = w_col_rd + c_col_w'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = w_new_col[r];
            end
        end

        if (w_emit) begin
            window_d = win_d;
            valid_d  = 1'b1;
            done_d   = (w_row_rd == c_row_last) && (w_col_rd == c_col_last);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            window_q <= window_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Line buffer storage is never cleared; rows 0 and 1 of each frame overwrite it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_accept) begin
            lb0_q[w_col_rd] <= lb1_q[w_col_rd];
            lb1_q[w_col_rd] <= bus.pixel_i;
        end
    end

    assign bus.window_o       = window_q;
    assign bus.window_valid_o = valid_q;
    assign bus.frame_done_o   = done_q;
endmodule
`default_nettype wire
